// File: rtl/reg_file_sb.sv
// reg_file_sb
// Integer register file with a pending-write scoreboard for the RISC-V core.
// Two combinational read ports, one synchronous write port, optional
// same-cycle write-to-read bypass. x0 always reads as zero and is never
// pending.
//
// Ports:
//   clk       clock; all state updates on posedge
//   rst       asynchronous active-high reset (regs, pend bits, pend_cnt)
//   a1, a2    read addresses
//   rd1, rd2  read data
//   busy1/2   register at a1/a2 has a write outstanding
//   we3       writeback enable
//   a3, wd3   writeback address and data
//   iss_v     issue of an instruction that writes iss_rd
//   iss_rd    destination register of the issuing instruction
//   pend_cnt  registered number of pending registers
module reg_file_sb #(
    parameter int          XLEN   = 32,
    parameter int unsigned NREGS  = 32,
    parameter int          AW     = $clog2(NREGS),
    parameter bit          BYPASS = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   a1,
    input  logic [AW-1:0]   a2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    output logic            busy1,
    output logic            busy2,
    input  logic            we3,
    input  logic [AW-1:0]   a3,
    input  logic [XLEN-1:0] wd3,
    input  logic            iss_v,
    input  logic [AW-1:0]   iss_rd,
    output logic [AW:0]     pend_cnt
);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] pend;
    logic [NREGS-1:0] pend_set;
    logic [NREGS-1:0] pend_clr;
    logic             cnt_inc;
    logic             cnt_dec;

    // One-hot set/clear masks; x0 never participates.
    always_comb begin
        pend_set = '0;
        pend_clr = '0;
        if (iss_v && iss_rd != '0)
            pend_set[iss_rd] = 1'b1;
        if (we3 && a3 != '0)
            pend_clr[a3] = 1'b1;
    end

    // Count moves by at most +1 (new issue to an idle register) and -1
    // (writeback of a pending register not re-issued this cycle).
    assign cnt_inc = |(pend_set & ~pend);
    assign cnt_dec = |(pend_clr & pend & ~pend_set);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend     <= '0;
            pend_cnt <= '0;
            for (int unsigned i = 0; i < NREGS; i++)
                regs[i] <= '0;
        end else begin
            // Set wins over clear on the same register.
            pend     <= (pend & ~pend_clr) | pend_set;
            pend_cnt <= pend_cnt + {{AW{1'b0}}, cnt_inc} - {{AW{1'b0}}, cnt_dec};
            if (we3 && a3 != '0)
                regs[a3] <= wd3;
        end
    end

    // Read port 1. A bypassed write retires the old instruction, so busy only
    // stays up if the same register is re-issued in this cycle.
    always_comb begin
        rd1   = '0;
        busy1 = 1'b0;
        if (!rst && a1 != '0) begin
            if (BYPASS && we3 && a3 == a1) begin
                rd1   = wd3;
                busy1 = iss_v && (iss_rd == a1);
            end else begin
                rd1   = regs[a1];
                busy1 = pend[a1];
            end
        end
    end

    // Read port 2, same rules as port 1.
    always_comb begin
        rd2   = '0;
        busy2 = 1'b0;
        if (!rst && a2 != '0) begin
            if (BYPASS && we3 && a3 == a2) begin
                rd2   = wd3;
                busy2 = iss_v && (iss_rd == a2);
            end else begin
                rd2   = regs[a2];
                busy2 = pend[a2];
            end
        end
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb
// Self-checking bench for reg_file_sb: BYPASS=1 and BYPASS=0 instances share
// stimulus and are checked against an array-based reference model; a third
// instance (NREGS=16, XLEN=64) gets a short directed sequence.
module tb_reg_file_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic        we3, iss_v;
    logic [4:0]  a1, a2, a3, iss_rd;
    logic [31:0] wd3;

    logic [31:0] rd1_b1, rd2_b1, rd1_b0, rd2_b0;
    logic        busy1_b1, busy2_b1, busy1_b0, busy2_b0;
    logic [5:0]  cnt_b1, cnt_b0;

    logic        w_we3, w_iv;
    logic [3:0]  w_a1, w_a2, w_a3, w_ird;
    logic [63:0] w_wd3, w_rd1, w_rd2;
    logic        w_busy1, w_busy2;
    logic [4:0]  w_cnt;

    int nc = 0;
    int nf = 0;

    always #5 clk = ~clk;

    reg_file_sb u_bp (
        .clk(clk), .rst(rst), .a1(a1), .a2(a2), .rd1(rd1_b1), .rd2(rd2_b1),
        .busy1(busy1_b1), .busy2(busy2_b1), .we3(we3), .a3(a3), .wd3(wd3),
        .iss_v(iss_v), .iss_rd(iss_rd), .pend_cnt(cnt_b1)
    );

    reg_file_sb #(.BYPASS(1'b0)) u_nb (
        .clk(clk), .rst(rst), .a1(a1), .a2(a2), .rd1(rd1_b0), .rd2(rd2_b0),
        .busy1(busy1_b0), .busy2(busy2_b0), .we3(we3), .a3(a3), .wd3(wd3),
        .iss_v(iss_v), .iss_rd(iss_rd), .pend_cnt(cnt_b0)
    );

    reg_file_sb #(.XLEN(64), .NREGS(16)) u_w (
        .clk(clk), .rst(rst), .a1(w_a1), .a2(w_a2), .rd1(w_rd1), .rd2(w_rd2),
        .busy1(w_busy1), .busy2(w_busy2), .we3(w_we3), .a3(w_a3), .wd3(w_wd3),
        .iss_v(w_iv), .iss_rd(w_ird), .pend_cnt(w_cnt)
    );

    // ---------------- reference model ----------------
    logic [31:0] m_regs [32];
    bit          m_pend [32];

    task automatic m_clear();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = '0;
            m_pend[i] = 1'b0;
        end
    endtask

    function automatic int m_cnt();
        int n = 0;
        for (int i = 0; i < 32; i++)
            n += int'(m_pend[i]);
        return n;
    endfunction

    task automatic m_read(input bit bp, input logic [4:0] a,
                          output logic [31:0] d, output logic b);
        d = '0;
        b = 1'b0;
        if (rst || a == 5'd0)
            return;
        if (bp && we3 && a3 == a) begin
            d = wd3;
            b = iss_v && iss_rd == a;
        end else begin
            d = m_regs[a];
            b = m_pend[a];
        end
    endtask

    task automatic m_edge();
        if (rst) begin
            m_clear();
            return;
        end
        if (we3 && a3 != 5'd0) begin
            m_regs[a3] = wd3;
            m_pend[a3] = 1'b0;
        end
        if (iss_v && iss_rd != 5'd0)
            m_pend[iss_rd] = 1'b1;
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nc++;
        if (act !== exp) begin
            nf++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic check_model();
        logic [31:0] d;
        logic        b;
        m_read(1'b1, a1, d, b);
        chk("bp.rd1", 64'(rd1_b1), 64'(d));   chk("bp.busy1", 64'(busy1_b1), 64'(b));
        m_read(1'b1, a2, d, b);
        chk("bp.rd2", 64'(rd2_b1), 64'(d));   chk("bp.busy2", 64'(busy2_b1), 64'(b));
        m_read(1'b0, a1, d, b);
        chk("nb.rd1", 64'(rd1_b0), 64'(d));   chk("nb.busy1", 64'(busy1_b0), 64'(b));
        m_read(1'b0, a2, d, b);
        chk("nb.rd2", 64'(rd2_b0), 64'(d));   chk("nb.busy2", 64'(busy2_b0), 64'(b));
        chk("bp.pend_cnt", 64'(cnt_b1), 64'(m_cnt()));
        chk("nb.pend_cnt", 64'(cnt_b0), 64'(m_cnt()));
    endtask

    // Inputs change at posedge+1; outputs sampled at negedge; model steps at posedge.
    task automatic sample();
        @(negedge clk);
        check_model();
    endtask

    task automatic step();
        @(posedge clk);
        m_edge();
        #1;
    endtask

    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic iv, input logic [4:0] ir,
                         input logic [4:0] ra1, input logic [4:0] ra2);
        we3 = we; a3 = wa; wd3 = wd; iss_v = iv; iss_rd = ir; a1 = ra1; a2 = ra2;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        iv;
        logic [4:0]  ir;
        logic [4:0]  ra;
        logic [31:0] e_rd_bp;
        logic        e_busy_bp;
        logic [31:0] e_rd_nb;
        logic        e_busy_nb;
        logic [5:0]  e_cnt;
    } vec_t;

    function automatic vec_t mk(input int we, input int wa, input logic [31:0] wd,
                                input int iv, input int ir, input int ra,
                                input logic [31:0] rbp, input int bbp,
                                input logic [31:0] rnb, input int bnb, input int cnt);
        vec_t v;
        v.we = 1'(we);  v.wa = 5'(wa);  v.wd = wd;  v.iv = 1'(iv);  v.ir = 5'(ir);
        v.ra = 5'(ra);  v.e_rd_bp = rbp;  v.e_busy_bp = 1'(bbp);
        v.e_rd_nb = rnb;  v.e_busy_nb = 1'(bnb);  v.e_cnt = 6'(cnt);
        return v;
    endfunction

    vec_t tbl [17];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t limit 200000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        //           we wa wd            iv ir ra  rd_bp        b  rd_nb        b  cnt
        tbl[0]  = mk(0, 0, 32'h0,        1, 5, 5,  32'h0,       0, 32'h0,       0, 0);
        tbl[1]  = mk(0, 0, 32'h0,        0, 0, 5,  32'h0,       1, 32'h0,       1, 1);
        tbl[2]  = mk(0, 0, 32'h0,        0, 0, 5,  32'h0,       1, 32'h0,       1, 1);
        tbl[3]  = mk(1, 5, 32'h1234,     0, 0, 5,  32'h1234,    0, 32'h0,       1, 1);
        tbl[4]  = mk(0, 0, 32'h0,        0, 0, 5,  32'h1234,    0, 32'h1234,    0, 0);
        tbl[5]  = mk(1, 0, 32'hDEADBEEF, 1, 0, 0,  32'h0,       0, 32'h0,       0, 0);
        tbl[6]  = mk(0, 0, 32'h0,        0, 0, 0,  32'h0,       0, 32'h0,       0, 0);
        tbl[7]  = mk(0, 0, 32'h0,        1, 7, 7,  32'h0,       0, 32'h0,       0, 0);
        tbl[8]  = mk(1, 7, 32'h77,       1, 7, 7,  32'h77,      1, 32'h0,       1, 1);
        tbl[9]  = mk(0, 0, 32'h0,        0, 0, 7,  32'h77,      1, 32'h77,      1, 1);
        tbl[10] = mk(1, 7, 32'h70,       0, 0, 7,  32'h70,      0, 32'h77,      1, 1);
        tbl[11] = mk(0, 0, 32'h0,        1, 1, 7,  32'h70,      0, 32'h70,      0, 0);
        tbl[12] = mk(0, 0, 32'h0,        1, 2, 1,  32'h0,       1, 32'h0,       1, 1);
        tbl[13] = mk(0, 0, 32'h0,        1, 3, 2,  32'h0,       1, 32'h0,       1, 2);
        tbl[14] = mk(1, 2, 32'h22,       0, 0, 2,  32'h22,      0, 32'h0,       1, 3);
        tbl[15] = mk(0, 0, 32'h0,        1, 1, 2,  32'h22,      0, 32'h22,      0, 2);
        tbl[16] = mk(0, 0, 32'h0,        0, 0, 1,  32'h0,       1, 32'h0,       1, 2);

        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        w_we3 = 0; w_a3 = 0; w_wd3 = 0; w_iv = 0; w_ird = 0; w_a1 = 0; w_a2 = 0;
        m_clear();
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        chk("reset.cnt_bp", 64'(cnt_b1), 64'd0);
        chk("reset.cnt_nb", 64'(cnt_b0), 64'd0);
        @(posedge clk);
        #1;

        // Directed table.
        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].iv, tbl[i].ir,
                  tbl[i].ra, tbl[i].ra ^ 5'd1);
            sample();
            chk($sformatf("tbl%0d.bp.rd1", i),   64'(rd1_b1),   64'(tbl[i].e_rd_bp));
            chk($sformatf("tbl%0d.bp.busy1", i), 64'(busy1_b1), 64'(tbl[i].e_busy_bp));
            chk($sformatf("tbl%0d.nb.rd1", i),   64'(rd1_b0),   64'(tbl[i].e_rd_nb));
            chk($sformatf("tbl%0d.nb.busy1", i), 64'(busy1_b0), 64'(tbl[i].e_busy_nb));
            chk($sformatf("tbl%0d.cnt", i),      64'(cnt_b1),   64'(tbl[i].e_cnt));
            step();
        end

        // Load every register, leave several pending, then reset mid-cycle.
        for (int r = 1; r < 32; r++) begin
            drive(1, 5'(r), $urandom | 32'h1, 1, 5'(r % 6), 5'(r), 5'(r - 1));
            sample();
            step();
        end
        drive(1, 5'd4, 32'hCAFE_F00D, 1, 5'd4, 5'd4, 5'd3);
        #2 rst = 1'b1;
        m_clear();
        #1;
        chk("async_rst.bp.rd1", 64'(rd1_b1), 64'd0);
        chk("async_rst.bp.busy1", 64'(busy1_b1), 64'd0);
        chk("async_rst.nb.rd2", 64'(rd2_b0), 64'd0);
        chk("async_rst.cnt", 64'(cnt_b1), 64'd0);
        check_model();
        sample();
        step();
        #2 rst = 1'b0;
        drive(0, 0, 0, 0, 0, 5'd3, 5'd4);
        sample();
        step();

        // Randomized traffic with address collisions favoured.
        for (int n = 0; n < 300; n++) begin
            logic [4:0] ra3, rir, r1, r2;
            ra3 = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 5)) : 5'($urandom);
            rir = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 5)) : 5'($urandom);
            r1  = ($urandom_range(0, 3) == 0) ? ra3 : 5'($urandom_range(0, 7));
            r2  = ($urandom_range(0, 3) == 0) ? rir : 5'($urandom);
            drive(1'($urandom), ra3, $urandom, 1'($urandom), rir, r1, r2);
            sample();
            step();
        end
        drive(0, 0, 0, 0, 0, 0, 0);

        // Wide instance: NREGS=16, XLEN=64.
        w_we3 = 1; w_a3 = 4'd15; w_wd3 = 64'hFFFF_FFFF_0000_0001; w_iv = 1; w_ird = 4'd15;
        w_a1 = 4'd15; w_a2 = 4'd0;
        @(negedge clk);
        chk("w.bypass_rd1", w_rd1, 64'hFFFF_FFFF_0000_0001);
        chk("w.bypass_busy1", 64'(w_busy1), 64'd1);
        chk("w.x0_rd2", w_rd2, 64'd0);
        @(posedge clk); #1;
        w_we3 = 0; w_iv = 0;
        @(negedge clk);
        chk("w.stored_rd1", w_rd1, 64'hFFFF_FFFF_0000_0001);
        chk("w.busy1", 64'(w_busy1), 64'd1);
        chk("w.cnt1", 64'(w_cnt), 64'd1);
        for (int i = 1; i < 15; i++) begin
            @(posedge clk); #1;
            w_iv = 1; w_ird = 4'(i);
        end
        @(posedge clk); #1;
        w_iv = 0;
        w_a2 = 4'd14;
        @(negedge clk);
        chk("w.cnt_full", 64'(w_cnt), 64'd15);
        chk("w.busy2", 64'(w_busy2), 64'd1);
        @(posedge clk); #1;
        w_we3 = 1; w_a3 = 4'd15; w_wd3 = 64'd0;
        @(negedge clk);
        chk("w.wb_rd1", w_rd1, 64'd0);
        chk("w.wb_busy1", 64'(w_busy1), 64'd0);
        @(posedge clk); #1;
        w_we3 = 0;
        @(negedge clk);
        chk("w.cnt_after_wb", 64'(w_cnt), 64'd14);
        chk("w.rd1_after_wb", w_rd1, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nc, nf);
        $finish;
    end

endmodule
